ctrl_loop_cnt: RTL and testbench
================================

// Module: ctrl_loop_cnt
// PURPOSE
//  Programmable NLEV-level nested loop counter for the SMAC control FSM.
//  Counts accumulator-valid events (AC3 results) through nested loops such as
//  filters-per-volume and volumes-per-layer; each loop bound is reloadable per layer.
//  Per-level count values, last-iteration flags and done pulses drive FSM transitions.
//  Supports wrap and saturate modes.
// PARAMETERS
//  NLEV  2    number of nested loop levels; level 0 is innermost, must be >= 1
//  MNO   288  largest bound any level can be programmed with
//  W     $clog2(MNO+1)  per-level count/bound width (derived, not overridden)
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         reset, asynchronous, active-low
//  valid_in   in   1         one counting event (AC3 register sample)
//  cnt_load   in   1         capture max_val bounds and zero all counts
//  cnt_clear  in   1         zero all counts and flags; bounds are kept
//  sat_mode   in   1         1 = hold after the final wrap, 0 = wrap and continue (sampled on load)
//  max_val    in   NLEV*W    bound of level k at [k*W +: W]
//  cnt_val    out  NLEV*W    current 0-based count of level k
//  last_lvl   out  NLEV      level k is on its final iteration (cnt==bound-1)
//  done_lvl   out  NLEV      1-cycle pulse: level k wrapped
//  done_all   out  1         1-cycle pulse: outermost level wrapped
//  busy       out  1         programmed and not saturated; valid_in is accepted
// BEHAVIOUR
//  - Reset: all counts 0, bounds 0 (unprogrammed), mode 0. done_lvl/done_all 0,
//    busy 0. last_lvl is decoded from state, so it is 0 while unprogrammed.
//  - Priority per cycle: cnt_clear > cnt_load > valid_in. Lower-priority inputs
//    in the same cycle are dropped, not deferred.
//  - Load:
//    - bound_k <= max_val_k, with 0 stored as 1 and values > MNO clamped to MNO.
//    - The mode register <= sat_mode. All counts <= 0. sat flag <= 0.
//  - Clear: counts <= 0; sat flag <= 0; done pulses <= 0. Bounds and mode are unchanged.
//  - Counting happens when valid_in && busy.
//    - Level 0 increments on every counting event.
//    - Level k>0 increments only when every level j<k is at bound_j-1.
//    - A level at bound-1 that would increment wraps to 0. Its done_lvl[k] goes
//      high on the next cycle for exactly 1 cycle.
//  - done_all equals done_lvl[NLEV-1].
//    - Full-sequence length is prod(bound_k) valid events.
//  - Saturate (mode=1): on the event that wraps the outermost level, counts do not
//    wrap. They hold at bound_k-1 for all k, sat flag <= 1, and busy drops the
//    next cycle. done pulses still fire once. Further valid_in is ignored until
//    load or clear.
//  - Wrap (mode=0): the sequence restarts from all-zero and busy stays 1.
//  - busy = (bounds programmed) && !sat flag. Unprogrammed means bound_0 == 0, which
//    is only possible after reset.
//  - Latency:
//    - cnt_val and done pulses are registered: they update 1 cycle after the
//      valid_in edge.
//    - last_lvl is combinational from the registered counts and bounds, 0 extra cycles.
//  - Bound 1 on a level: last_lvl[k] is constantly 1; that level wraps every time it
//    is stepped.
//  - Reset mid-count returns to unprogrammed; bounds must be reloaded.
//  - Arithmetic: all compares are unsigned W-bit; bound-1 never underflows because
//    stored bounds are >= 1.
// TESTING
//  1. Reset, then valid_in x5 with no load -> cnt_val stays 0, busy=0, no done pulses.
//  2. Load NLEV=2, bounds {3,4}, mode 0; 12 valid -> done_lvl[0] on valids 4,8,12.
//     done_all after valid 12. Counts back to 0.
//  3. Load bounds {2,2}, mode 1; 6 valid -> done_all once after valid 4.
//     Counts hold {1,1}, busy=0. Valids 5-6 ignored. cnt_clear -> counts 0, busy=1.
//  4. Simultaneous cnt_load+valid_in with bound 3 -> counts 0 after the edge, the
//     valid is dropped. Then clear+load together -> bounds unchanged.
//  5. Load max_val 0 and 300 (MNO=288) -> stored bounds 1 and 288.
//     last_lvl[0] is constantly 1. Level 1 wraps after 288 events.
//  6. Assert rst_n low after 7 valid events (bounds {3,4}) -> all outputs 0 at once.
//     Further valid is ignored until reload.

Source files
------------

// File: rtl/ctrl_loop_cnt_if.sv
// Control/status bundle for the nested loop counter.
// The master drives the events and bounds. The slave (the counter) returns counts and flags.
interface ctrl_loop_cnt_if #(
  parameter int NLEV = 2,
  parameter int W    = 9
);
  logic              valid_in;
  logic              cnt_load;
  logic              cnt_clear;
  logic              sat_mode;
  logic [NLEV*W-1:0] max_val;
  logic [NLEV*W-1:0] cnt_val;
  logic [NLEV-1:0]   last_lvl;
  logic [NLEV-1:0]   done_lvl;
  logic              done_all;
  logic              busy;

  modport master (
    output valid_in, cnt_load, cnt_clear, sat_mode, max_val,
    input  cnt_val, last_lvl, done_lvl, done_all, busy
  );

  modport slave (
    input  valid_in, cnt_load, cnt_clear, sat_mode, max_val,
    output cnt_val, last_lvl, done_lvl, done_all, busy
  );
endinterface

// File: rtl/ctrl_loop_cnt.sv
// Programmable NLEV-level nested loop counter that counts accumulator-valid events.
// Level 0 is the innermost level. The counter can wrap or saturate after the full sequence.
module ctrl_loop_cnt #(
  parameter  int NLEV = 2,
  parameter  int MNO  = 288,
  localparam int W    = $clog2(MNO + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_loop_cnt_if.slave bus
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = W'(1);
  localparam logic [W-1:0] MNO_W  = W'(MNO);

  logic [W-1:0]      cnt_r   [NLEV];
  logic [W-1:0]      bound_r [NLEV];
  logic              mode_r;
  logic              sat_r;
  logic [NLEV-1:0]   done_r;

  logic              programmed_s;
  logic              busy_s;
  logic              count_en_s;
  logic [NLEV-1:0]   last_s;
  logic [NLEV-1:0]   step_s;
  logic [NLEV-1:0]   wrap_s;
  logic [NLEV*W-1:0] cnt_flat_s;

  // A bound of zero means one iteration. Bounds above MNO are clamped, so bound-1 never underflows.
  function automatic logic [W-1:0] clamp_bound(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v == ZERO_W) begin
      r = ONE_W;
    end else if (v > MNO_W) begin
      r = MNO_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Carry chain: a level steps only when every inner level is on its last iteration.
  always_comb begin
    logic carry;
    programmed_s = (bound_r[0] != ZERO_W);
    busy_s       = programmed_s && !sat_r;
    count_en_s   = bus.valid_in && busy_s;
    last_s       = {NLEV{1'b0}};
    step_s       = {NLEV{1'b0}};
    wrap_s       = {NLEV{1'b0}};
    cnt_flat_s   = {(NLEV*W){1'b0}};
    carry        = count_en_s;
    for (int k = 0; k < NLEV; k++) begin
      last_s[k]             = programmed_s && (cnt_r[k] == (bound_r[k] - ONE_W));
      step_s[k]             = carry;
      wrap_s[k]             = carry && last_s[k];
      carry                 = carry && last_s[k];
      cnt_flat_s[k*W +: W]  = cnt_r[k];
    end
  end

  // Counter state: clear beats load, and load beats counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NLEV; k++) begin
        cnt_r[k]   <= ZERO_W;
        bound_r[k] <= ZERO_W;
      end
      mode_r <= 1'b0;
      sat_r  <= 1'b0;
      done_r <= {NLEV{1'b0}};
    end else if (bus.cnt_clear) begin
      for (int k = 0; k < NLEV; k++) begin
        cnt_r[k] <= ZERO_W;
      end
      sat_r  <= 1'b0;
      done_r <= {NLEV{1'b0}};
    end else if (bus.cnt_load) begin
      for (int k = 0; k < NLEV; k++) begin
        bound_r[k] <= clamp_bound(bus.max_val[k*W +: W]);
        cnt_r[k]   <= ZERO_W;
      end
      mode_r <= bus.sat_mode;
      sat_r  <= 1'b0;
      done_r <= {NLEV{1'b0}};
    end else begin
      done_r <= wrap_s;
      if (wrap_s[NLEV-1] && mode_r) begin
        // Final wrap in saturate mode: every level already sits at bound-1, so hold it there.
        sat_r <= 1'b1;
      end else begin
        for (int k = 0; k < NLEV; k++) begin
          if (wrap_s[k]) begin
            cnt_r[k] <= ZERO_W;
          end else if (step_s[k]) begin
            cnt_r[k] <= cnt_r[k] + ONE_W;
          end else begin
            cnt_r[k] <= cnt_r[k];
          end
        end
      end
    end
  end

  assign bus.cnt_val  = cnt_flat_s;
  assign bus.last_lvl = last_s;
  assign bus.done_lvl = done_r;
  assign bus.done_all = done_r[NLEV-1];
  assign bus.busy     = busy_s;

endmodule

// File: tb/tb_ctrl_loop_cnt.sv
// Self-checking bench for ctrl_loop_cnt.
// An event-index model checks the outputs every cycle, and directed scenarios check literal values.
module tb_ctrl_loop_cnt;
  localparam int NLEV = 2;
  localparam int MNO  = 288;
  localparam int W    = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ctrl_loop_cnt_if #(.NLEV(NLEV), .W(W)) bus ();

  ctrl_loop_cnt #(.NLEV(NLEV), .MNO(MNO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The model stores the position in the full sequence as a single event index.
  // Each level's count is one digit of that index in mixed radix.
  logic            m_prog, m_mode, m_sat;
  int              m_n;
  int              m_b [NLEV];
  logic [NLEV-1:0] m_done;

  function automatic int prod_upto(input int k);
    int p = 1;
    for (int j = 0; j < k; j++) p = p * m_b[j];
    return p;
  endfunction

  function automatic int clampi(input int v);
    if (v == 0) return 1;
    if (v > MNO) return MNO;
    return v;
  endfunction

  function automatic logic [NLEV-1:0] wraps_of(input int n);
    logic [NLEV-1:0] w = '0;
    for (int k = 0; k < NLEV; k++) w[k] = ((n + 1) % prod_upto(k + 1)) == 0;
    return w;
  endfunction

  function automatic logic [NLEV*W-1:0] exp_cnt();
    logic [NLEV*W-1:0] r = '0;
    if (m_prog)
      for (int k = 0; k < NLEV; k++) r[k*W +: W] = W'((m_n / prod_upto(k)) % m_b[k]);
    return r;
  endfunction

  function automatic logic [NLEV-1:0] exp_last();
    logic [NLEV-1:0] r = '0;
    if (m_prog)
      for (int k = 0; k < NLEV; k++) r[k] = ((m_n / prod_upto(k)) % m_b[k]) == (m_b[k] - 1);
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prog <= 1'b0; m_mode <= 1'b0; m_sat <= 1'b0; m_n <= 0; m_done <= '0;
      for (int k = 0; k < NLEV; k++) m_b[k] <= 0;
    end else if (bus.cnt_clear) begin
      m_n <= 0; m_sat <= 1'b0; m_done <= '0;
    end else if (bus.cnt_load) begin
      for (int k = 0; k < NLEV; k++) m_b[k] <= clampi(int'(bus.max_val[k*W +: W]));
      m_mode <= bus.sat_mode; m_prog <= 1'b1; m_n <= 0; m_sat <= 1'b0; m_done <= '0;
    end else if (bus.valid_in && m_prog && !m_sat) begin
      m_done <= wraps_of(m_n);
      if (m_n + 1 == prod_upto(NLEV)) begin
        if (m_mode) m_sat <= 1'b1;
        else        m_n   <= 0;
      end else begin
        m_n <= m_n + 1;
      end
    end else begin
      m_done <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("cnt_val",  32'(bus.cnt_val),  32'(exp_cnt()));
    chk("last_lvl", 32'(bus.last_lvl), 32'(exp_last()));
    chk("done_lvl", 32'(bus.done_lvl), 32'(m_done));
    chk("done_all", 32'(bus.done_all), 32'(m_done[NLEV-1]));
    chk("busy",     32'(bus.busy),     32'(m_prog && !m_sat));
  end

  task automatic drive(input logic v, input logic ld, input logic cl, input logic sm,
                       input logic [NLEV*W-1:0] mv);
    bus.valid_in  = v;
    bus.cnt_load  = ld;
    bus.cnt_clear = cl;
    bus.sat_mode  = sm;
    bus.max_val   = mv;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.cnt_load = 1'b0; bus.cnt_clear = 1'b0;
    bus.sat_mode = 1'b0; bus.max_val = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Valid events with no bounds loaded are ignored.
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t1_cnt",  32'(bus.cnt_val),  32'd0);
    chk("t1_busy", 32'(bus.busy),     32'd0);
    chk("t1_done", 32'(bus.done_lvl), 32'd0);

    // Load level1=3, level0=4 in wrap mode.
    drive(1'b0, 1'b1, 1'b0, 1'b0, {9'd3, 9'd4});
    chk("t2_busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, {9'd3, 9'd4});
      chk("t2_done0",   32'(bus.done_lvl[0]), 32'(i % 4 == 0));
      chk("t2_doneall", 32'(bus.done_all),    32'(i == 12));
      if (i == 7) chk("t2_cnt7", 32'(bus.cnt_val), 32'({9'd1, 9'd3}));
    end
    chk("t2_cnt_end", 32'(bus.cnt_val), 32'd0);
    chk("t2_busy_end", 32'(bus.busy), 32'd1);

    // Load bounds {2,2} in saturate mode.
    drive(1'b0, 1'b1, 1'b0, 1'b1, {9'd2, 9'd2});
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, {9'd2, 9'd2});
      chk("t3_doneall", 32'(bus.done_all), 32'(i == 4));
      chk("t3_busy",    32'(bus.busy),     32'(i < 4));
    end
    chk("t3_hold", 32'(bus.cnt_val), 32'({9'd1, 9'd1}));
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("t3_clr_cnt",  32'(bus.cnt_val), 32'd0);
    chk("t3_clr_busy", 32'(bus.busy),    32'd1);

    // Priority: a load drops a simultaneous valid, and a clear overrides a simultaneous load.
    drive(1'b1, 1'b1, 1'b0, 1'b0, {9'd3, 9'd3});
    chk("t4_load_drop", 32'(bus.cnt_val), 32'd0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t4_cnt3", 32'(bus.cnt_val), 32'({9'd1, 9'd0}));
    drive(1'b0, 1'b1, 1'b1, 1'b0, {9'd2, 9'd2});
    chk("t4_clr", 32'(bus.cnt_val), 32'd0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t4_bounds_kept", 32'(bus.cnt_val), 32'({9'd1, 9'd0}));

    // Clamping: a max_val of 0 is stored as 1, and 300 is stored as 288.
    drive(1'b0, 1'b1, 1'b0, 1'b0, {9'd300, 9'd0});
    chk("t5_last0", 32'(bus.last_lvl[0]), 32'd1);
    for (int i = 1; i <= 288; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      if (i == 287) begin
        chk("t5_cnt287",  32'(bus.cnt_val),  32'({9'd287, 9'd0}));
        chk("t5_nodone",  32'(bus.done_all), 32'd0);
        chk("t5_last287", 32'(bus.last_lvl), 32'd3);
      end
    end
    chk("t5_done288", 32'(bus.done_all), 32'd1);
    chk("t5_cnt288",  32'(bus.cnt_val),  32'd0);

    // An asynchronous reset mid-count clears all outputs immediately.
    drive(1'b0, 1'b1, 1'b0, 1'b0, {9'd3, 9'd4});
    repeat (7) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t6_pre", 32'(bus.cnt_val), 32'({9'd1, 9'd3}));
    rst_n = 1'b0;
    #1;
    chk("t6_cnt",  32'(bus.cnt_val),  32'd0);
    chk("t6_busy", 32'(bus.busy),     32'd0);
    chk("t6_last", 32'(bus.last_lvl), 32'd0);
    chk("t6_done", 32'(bus.done_lvl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("t6_ign_cnt",  32'(bus.cnt_val), 32'd0);
    chk("t6_ign_busy", 32'(bus.busy),    32'd0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
